// File: rtl/bcd_to_bin_converter.sv
// Iterative BCD-to-binary converter using reverse double dabble: one shift/adjust
// step per clock, BIN_W steps per conversion, with up-front rejection of invalid digits.
module bcd_to_bin_converter #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              r_state;
  logic [4*DIGITS-1:0] r_bcd;
  logic [BIN_W-1:0]    r_res;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_bin;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_bcdValid;
  logic [4*DIGITS-1:0] w_shiftBcd;
  logic [4*DIGITS-1:0] w_adjBcd;
  logic [BIN_W-1:0]    w_shiftRes;

  always_comb begin
    w_bcdValid = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] > 4'd9) w_bcdValid = 1'b0;
    end
  end

  // One iteration: the BCD LSB drops into the result MSB, then any digit that
  // received a halved "ten" (value >= 8) is corrected by subtracting 3.
  always_comb begin
    w_shiftBcd = r_bcd >> 1;
    w_shiftRes = {r_bcd[0], r_res[BIN_W-1:1]};
    w_adjBcd   = w_shiftBcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shiftBcd[4*d +: 4] >= 4'd8) w_adjBcd[4*d +: 4] = w_shiftBcd[4*d +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bcd   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_bcdValid) begin
              r_bcd   <= bcd;
              r_res   <= '0;
              r_cnt   <= '0;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end else begin
              r_err  <= 1'b1;
              r_bin  <= '0;
              r_done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_bcd <= w_adjBcd;
          r_res <= w_shiftRes;
          // The final shift result is taken directly so bin is valid with done.
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_bin   <= w_shiftRes;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bin  = r_bin;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Self-checking bench for bcd_to_bin_converter: a cycle-level arithmetic model
// checked every cycle, plus directed vectors with hand-computed literal results.
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic [4*DIGITS-1:0] bcd = '0;
  logic [BIN_W-1:0]   bin;
  logic               busy;
  logic               done;
  logic               err;

  int checkCount = 0;
  int errorCount = 0;
  bit cmpEn = 1'b0;

  bcd_to_bin_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
    .bin(bin), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit bcdIsValid(input logic [4*DIGITS-1:0] v);
    for (int d = 0; d < DIGITS; d++) if (v[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcdValue(input logic [4*DIGITS-1:0] v);
    int acc = 0;
    for (int d = DIGITS - 1; d >= 0; d--) acc = acc * 10 + int'(v[4*d +: 4]);
    return acc;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: value from decimal arithmetic, timing as a countdown of BIN_W cycles.
  bit mBusy = 1'b0;
  bit mDone = 1'b0;
  bit mErr  = 1'b0;
  int mCnt  = 0;
  int mVal  = 0;
  int mBin  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 1'b0; mDone <= 1'b0; mErr <= 1'b0; mCnt <= 0; mVal <= 0; mBin <= 0;
    end else begin
      mDone <= 1'b0;
      if (!mBusy) begin
        if (start) begin
          if (bcdIsValid(bcd)) begin
            mBusy <= 1'b1; mCnt <= BIN_W; mVal <= bcdValue(bcd); mErr <= 1'b0;
          end else begin
            mErr <= 1'b1; mBin <= 0; mDone <= 1'b1;
          end
        end
      end else begin
        if (mCnt == 1) begin
          mBusy <= 1'b0; mBin <= mVal; mDone <= 1'b1;
        end
        mCnt <= mCnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cmp_bin",  int'(bin),  mBin);
      checkOutput("cmp_busy", int'(busy), int'(mBusy));
      checkOutput("cmp_done", int'(done), int'(mDone));
      checkOutput("cmp_err",  int'(err),  int'(mErr));
    end
  end

  // One start pulse, then scramble bcd and wait (bounded) for done.
  task automatic applyStimulus(input logic [4*DIGITS-1:0] v, input int expBin,
                               input int expErr, input int expLat, input int expBusy);
    int cyc = 0;
    int busyCnt = 0;
    bcd = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd = 12'h555;
    while (!done && cyc < 30) begin
      if (busy) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    checkOutput($sformatf("latency_%h", v), cyc, expLat);
    checkOutput($sformatf("bin_%h", v), int'(bin), expBin);
    checkOutput($sformatf("err_%h", v), int'(err), expErr);
    checkOutput($sformatf("busyCycles_%h", v), busyCnt, expBusy);
    @(negedge clk);
  endtask

  initial begin
    int dones;
    int gotBin;
    int firstCyc;
    int secondCyc;
    bit finished;

    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_bin", int'(bin), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    cmpEn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(12'h999, 999, 0, 10, 10);
    applyStimulus(12'h000, 0,   0, 10, 10);
    applyStimulus(12'h255, 255, 0, 10, 10);
    applyStimulus(12'h1A3, 0,   1, 0,  0);
    applyStimulus(12'h019, 19,  0, 10, 10);
    applyStimulus(12'hF00, 0,   1, 0,  0);
    applyStimulus(12'h908, 908, 0, 10, 10);
    applyStimulus(12'h00C, 0,   1, 0,  0);

    // A second start on the 4th busy cycle must be ignored.
    bcd = 12'h123;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bcd = 12'h456;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    gotBin = -1;
    for (int c = 0; c < 25; c++) begin
      if (done) begin
        dones++;
        gotBin = int'(bin);
      end
      @(negedge clk);
    end
    checkOutput("ignore_start_dones", dones, 1);
    checkOutput("ignore_start_bin", gotBin, 123);

    // Reset on the 5th busy cycle aborts with no done pulse.
    bcd = 12'h777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_bin", int'(bin), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    checkOutput("midreset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checkOutput("midreset_no_done", dones, 0);
    applyStimulus(12'h042, 42, 0, 10, 10);

    // Back-to-back: start held high, operand changed in the done cycle.
    bcd = 12'h010;
    start = 1'b1;
    firstCyc = -100;
    secondCyc = -1;
    finished = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      if (done) begin
        if (firstCyc < 0) begin
          firstCyc = c;
          checkOutput("b2b_first_bin", int'(bin), 10);
          bcd = 12'h020;
        end else begin
          secondCyc = c;
          checkOutput("b2b_second_bin", int'(bin), 20);
          start = 1'b0;
          finished = 1'b1;
        end
      end
    end
    start = 1'b0;
    checkOutput("b2b_spacing", secondCyc - firstCyc, 11);
    repeat (15) @(negedge clk);

    cmpEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
